// File: rtl/apb4_slave_mem.sv
// APB4 completer: byte-strobed word memory with fixed wait states, PSLVERR on
// illegal accesses, a saturating error counter and a sticky protocol-violation flag.
module apb4_slave_mem #(
  parameter int unsigned addr_width  = 32,
  parameter int unsigned data_width  = 32,
  parameter int unsigned mem_depth   = 64,
  parameter int unsigned wait_cycles = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [addr_width-1:0]   PADDR,
  input  logic [data_width-1:0]   PWDATA,
  input  logic [data_width/8-1:0] PSTRB,
  output logic [data_width-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [1:0]              ps,
  output logic [15:0]             err_count,
  output logic                    proto_err
);

  localparam int unsigned strb_w = data_width / 8;
  localparam int unsigned off_w  = $clog2(strb_w);
  localparam int unsigned idx_w  = $clog2(mem_depth);
  localparam logic [addr_width-1:0] off_mask = addr_width'(strb_w - 1);
  localparam logic [addr_width-1:0] depth_a  = addr_width'(mem_depth);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [addr_width-1:0] addr;
    logic                  wr;
    logic [data_width-1:0] wdata;
    logic [strb_w-1:0]     strb;
  } req_t;

  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  req_t                  cap_q, bus_req;
  logic [data_width-1:0] mem [mem_depth];
  logic [data_width-1:0] wmask;
  logic [addr_width-1:0] word_addr;
  logic [idx_w-1:0]      idx;
  logic                  in_xfer, acc, ready, addr_err, viol, cap_en, wr_en;

  assign bus_req = '{addr: PADDR, wr: PWRITE, wdata: PWDATA, strb: PSTRB};

  // Bus phase as seen on the wires this cycle
  always_comb begin
    if (!PSEL)         ps = 2'd0;
    else if (!PENABLE) ps = 2'd1;
    else               ps = 2'd2;
  end

  // Address decode: out-of-range word, misaligned byte offset, or strobes on a read
  assign word_addr = PADDR >> off_w;
  assign idx       = idx_w'(word_addr);
  assign addr_err  = (word_addr >= depth_a) || ((PADDR & off_mask) != '0)
                     || (!PWRITE && (PSTRB != '0));

  for (genvar b = 0; b < strb_w; b++) begin : g_wmask
    assign wmask[b*8 +: 8] = {8{PSTRB[b]}};
  end

  // Registered SETUP means the SETUP cycle was sampled, so the very next bus cycle is
  // the first ACCESS cycle; wcnt counts the remaining wait states from there.
  assign in_xfer = (state_q != S_IDLE);
  assign acc     = in_xfer && PSEL && PENABLE;
  assign ready   = acc && (wcnt_q == 4'd0);
  assign viol    = in_xfer ? (!(PSEL && PENABLE) || (bus_req != cap_q))
                           : PENABLE;

  assign PREADY  = ready;
  assign PSLVERR = ready && addr_err;
  assign PRDATA  = (ready && !addr_err && !PWRITE) ? mem[idx] : '0;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cap_en  = 1'b0;
    wr_en   = 1'b0;
    if (viol) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_d = S_SETUP;
            wcnt_d  = 4'(wait_cycles);
            cap_en  = 1'b1;
          end
        end
        S_SETUP, S_ACCESS: begin
          if (ready) begin
            state_d = S_IDLE;
            wr_en   = PWRITE && !addr_err;
          end else begin
            state_d = S_ACCESS;
            wcnt_d  = wcnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Captured request, memory and status counters
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cap_q     <= '0;
      mem       <= '{default: '0};
      err_count <= '0;
      proto_err <= 1'b0;
    end else begin
      if (cap_en) cap_q <= bus_req;
      if (wr_en) mem[idx] <= (mem[idx] & ~wmask) | (PWDATA & wmask);
      if (PSLVERR && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      if (viol) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Bench for apb4_slave_mem: a 2-wait-state and a 0-wait-state instance, each checked
// every cycle against a transfer-level model, plus directed literal expectations.
module tb_apb4_slave_mem;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel   [N];
  logic        pen    [N];
  logic        pwr    [N];
  logic [31:0] paddr  [N];
  logic [31:0] pwdata [N];
  logic [3:0]  pstrb  [N];
  logic [31:0] prdata [N];
  logic        pready [N];
  logic        pslverr[N];
  logic [1:0]  ps     [N];
  logic [15:0] errc   [N];
  logic        perr   [N];

  apb4_slave_mem #(.addr_width(32), .data_width(32), .mem_depth(64), .wait_cycles(2)) u_dut_w2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]), .ps(ps[0]), .err_count(errc[0]),
    .proto_err(perr[0]));

  apb4_slave_mem #(.addr_width(32), .data_width(32), .mem_depth(64), .wait_cycles(0)) u_dut_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]), .ps(ps[1]), .err_count(errc[1]),
    .proto_err(perr[1]));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transfer-level model: a transfer starts in its SETUP cycle and must complete
  // exactly 1+wait cycles later; the word store is updated only on a clean write.
  logic [31:0] m_mem   [N][64];
  bit          m_act   [N];
  int          m_setup [N];
  int          m_errc  [N];
  bit          m_proto [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_wdata [N];
  logic [3:0]  m_strb  [N];
  logic        m_wr    [N];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_err(input logic [31:0] a, input logic wr, input logic [3:0] st);
    return ((a / 4) >= 64) || ((a % 4) != 0) || (!wr && (st != 4'h0));
  endfunction

  bit          e_rdy, e_err, e_viol;
  logic [1:0]  e_ps;
  logic [31:0] e_rd;

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      e_ps = !psel[d] ? 2'd0 : (!pen[d] ? 2'd1 : 2'd2);
      if (!rst_n) begin
        for (int w = 0; w < 64; w++) m_mem[d][w] = 32'h0;
        m_act[d] = 0; m_errc[d] = 0; m_proto[d] = 0;
        e_rdy = 0; e_err = 0;
      end else begin
        e_err = addr_err(paddr[d], pwr[d], pstrb[d]);
        e_rdy = m_act[d] && psel[d] && pen[d] && (cyc == m_setup[d] + 1 + wait_of(d));
      end
      e_rd = (e_rdy && !e_err && !pwr[d]) ? m_mem[d][paddr[d][7:2]] : 32'h0;
      chk($sformatf("pready%0d", d), pready[d], e_rdy);
      chk($sformatf("pslverr%0d", d), pslverr[d], e_rdy && e_err);
      chk($sformatf("prdata%0d", d), prdata[d], e_rd);
      chk($sformatf("ps%0d", d), ps[d], e_ps);
      chk($sformatf("err_count%0d", d), errc[d], m_errc[d]);
      chk($sformatf("proto_err%0d", d), perr[d], m_proto[d]);
      if (rst_n) begin
        e_viol = m_act[d] ? (!(psel[d] && pen[d]) || paddr[d] != m_addr[d] || pwr[d] != m_wr[d]
                             || pwdata[d] != m_wdata[d] || pstrb[d] != m_strb[d])
                          : pen[d];
        if (e_rdy && e_err && m_errc[d] < 65535) m_errc[d]++;
        if (e_viol) begin
          m_proto[d] = 1; m_act[d] = 0;
        end else if (m_act[d]) begin
          if (e_rdy) begin
            if (pwr[d] && !e_err)
              for (int b = 0; b < 4; b++)
                if (pstrb[d][b]) m_mem[d][paddr[d][7:2]][b*8 +: 8] = pwdata[d][b*8 +: 8];
            m_act[d] = 0;
          end
        end else if (psel[d] && !pen[d]) begin
          m_act[d] = 1; m_setup[d] = cyc;
          m_addr[d] = paddr[d]; m_wr[d] = pwr[d]; m_wdata[d] = pwdata[d]; m_strb[d] = pstrb[d];
        end
      end
    end
  end

  // One transfer on bus d; entered and left just after a rising edge. keep=1 leaves the
  // bus in ACCESS so the caller can start the next SETUP with no idle cycle.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit keep,
                      output logic [31:0] rd, output logic er, output int lat);
    bit done;
    psel[d] = 1; pen[d] = 0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    rd = '0; er = 0; lat = 0; done = 0;
    @(posedge clk); #1;
    pen[d] = 1;
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1; lat = i; rd = prdata[d]; er = pslverr[d];
      end
      @(posedge clk); #1;
    end
    chk($sformatf("xfer_done%0d_%0h", d, a), done, 1);
    if (!keep || !done) begin psel[d] = 0; pen[d] = 0; end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < N; d++) begin
      psel[d] = 0; pen[d] = 0; pwr[d] = 0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", pready[0], 0);
    chk("rst_prdata", prdata[0], 0);
    chk("rst_ps", ps[0], 0);
    chk("rst_errc", errc[0], 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Read after reset: ready 3 cycles after SETUP, zero data, no error
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd00_lat", lat, 3);
    chk("rd00_data", rd, 32'h0);
    chk("rd00_err", er, 0);

    // Full write then single-byte strobe merge
    xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("wr08_err", er, 0);
    xfer(0, 1, 32'h08, 32'h00000011, 4'h1, 0, rd, er, lat);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd08_merge", rd, 32'hDEADBE11);

    // Last legal word
    xfer(0, 1, 32'hFC, 32'hA5A55A5A, 4'hF, 0, rd, er, lat);
    chk("wrFC_err", er, 0);
    xfer(0, 0, 32'hFC, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rdFC_data", rd, 32'hA5A55A5A);

    // Out-of-range and misaligned accesses
    xfer(0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    chk("wr100_err", er, 1);
    xfer(0, 0, 32'h03, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd03_err", er, 1);
    chk("rd03_data", rd, 32'h0);
    chk("errc_2", errc[0], 2);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd00_unchanged", rd, 32'h0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd08_unchanged", rd, 32'hDEADBE11);

    // Strobes on a read are illegal
    xfer(0, 0, 32'h08, 32'h0, 4'h1, 0, rd, er, lat);
    chk("rdstrb_err", er, 1);
    chk("rdstrb_data", rd, 32'h0);
    chk("errc_3", errc[0], 3);

    // Back-to-back write/read with zero wait states
    xfer(1, 1, 32'h04, 32'h12345678, 4'hF, 1, rd, er, lat);
    chk("b2b_wr_lat", lat, 1);
    xfer(1, 0, 32'h04, 32'h0, 4'h0, 0, rd, er, lat);
    chk("b2b_rd_lat", lat, 1);
    chk("b2b_rd_data", rd, 32'h12345678);

    // PSEL dropped during a wait state
    psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 32'h0C; pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
    @(posedge clk); #1; pen[0] = 1;
    @(posedge clk); #1; psel[0] = 0; pen[0] = 0;
    @(posedge clk); #1;
    chk("drop_proto", perr[0], 1);
    xfer(0, 0, 32'h0C, 32'h0, 4'h0, 0, rd, er, lat);
    chk("drop_rd0C", rd, 32'h0);
    chk("drop_rd0C_err", er, 0);

    // Reset asserted in the completing ACCESS cycle of a write
    psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 32'h10; pwdata[0] = 32'hCAFEF00D; pstrb[0] = 4'hF;
    @(posedge clk); #1; pen[0] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("prerst_ready", pready[0], 1);
    rst_n = 0;
    #1;
    chk("midrst_pready", pready[0], 0);
    chk("midrst_pslverr", pslverr[0], 0);
    chk("midrst_prdata", prdata[0], 0);
    chk("midrst_errc", errc[0], 0);
    chk("midrst_proto", perr[0], 0);
    @(posedge clk); #1; psel[0] = 0; pen[0] = 0;
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("postrst_rd10", rd, 32'h0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    chk("postrst_rd08", rd, 32'h0);
    xfer(1, 0, 32'h04, 32'h0, 4'h0, 0, rd, er, lat);
    chk("postrst_w0_rd04", rd, 32'h0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
